// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and the controller that consumes its ir.
// Holds the FSM encoding and the instruction-word field positions.
package instr_fetch_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam int HALT_BIT = 31;
  localparam int OPC_MSB  = 30;
  localparam int OPC_LSB  = 25;

  function automatic logic is_halt(input logic [31:0] word);
    return word[HALT_BIT];
  endfunction

  function automatic logic [OPC_MSB-OPC_LSB:0] opcode(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue front end: reads words from a synchronous instruction memory
// and hands them to the controller one at a time until a HALT word or a stop request.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              stop,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count,
  output state_t            fsm_state
);

  // Handshake: ir is transferred on a rising edge where ir_valid && ir_ready; once
  // ir_valid is raised, ir and ir_valid stay stable until that edge (or stop/reset).
  state_t state;

  assign fsm_state = state;
  assign imem_rd   = (state == S_FETCH);
  assign imem_addr = pc;
  assign busy      = (state == S_FETCH) || (state == S_WAIT) || (state == S_ISSUE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      ir          <= '0;
      ir_valid    <= 1'b0;
      pc          <= '0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else if (stop && state != S_IDLE) begin
      // Abort drops any read in flight and any handshake in this cycle.
      state    <= S_IDLE;
      ir_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start && !stop) begin
            pc          <= start_pc;
            instr_count <= '0;
            halted      <= 1'b0;
            state       <= S_FETCH;
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          ir <= imem_rdata;
          if (is_halt(imem_rdata)) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            ir_valid <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ir_valid && ir_ready) begin
            ir_valid <= 1'b0;
            pc       <= pc + 1'b1;
            if (!(&instr_count)) instr_count <= instr_count + 1'b1;
            state    <= S_FETCH;
          end
        end
        default: begin
          state    <= S_IDLE;
          ir_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle-by-cycle vector table plus an async-reset sequence.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam logic [31:0] W_A  = 32'h5000000D;
  localparam logic [31:0] W_B  = 32'h5010800C;
  localparam logic [31:0] W_H  = 32'h80000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  start_pc = '0;
  logic        stop = 1'b0;
  logic        imem_rd;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic [15:0] instr_count;
  state_t      fsm_state;

  logic [31:0] mem [256];

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic        start;
    logic [7:0]  start_pc;
    logic        stop;
    logic        ready;
    state_t      st;
    logic [31:0] ir;
    logic        valid;
    logic [7:0]  pc;
    logic        halted;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  instr_fetch_unit #(.ADDR_W(8), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .stop(stop),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready), .pc(pc), .busy(busy),
    .halted(halted), .instr_count(instr_count), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (imem_rd) imem_rdata <= mem[imem_addr];
  end

  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s.%s got %h want %h", n, f, act, exp);
    end
  endtask

  task automatic add(input string n, input logic s, input logic [7:0] sp, input logic sto,
                     input logic rdy, input state_t st, input logic [31:0] eir, input logic v,
                     input logic [7:0] epc, input logic h, input logic [15:0] c);
    vec_t r;
    r.name = n; r.start = s; r.start_pc = sp; r.stop = sto; r.ready = rdy;
    r.st = st; r.ir = eir; r.valid = v; r.pc = epc; r.halted = h; r.cnt = c;
    vecs.push_back(r);
  endtask

  task automatic check_outputs(input vec_t v);
    logic exp_rd;
    logic exp_busy;
    exp_rd   = (v.st == S_FETCH);
    exp_busy = (v.st == S_FETCH) || (v.st == S_WAIT) || (v.st == S_ISSUE);
    chk(v.name, "state", 32'(fsm_state), 32'(v.st));
    chk(v.name, "imem_rd", 32'(imem_rd), 32'(exp_rd));
    if (exp_rd) chk(v.name, "imem_addr", 32'(imem_addr), 32'(v.pc));
    chk(v.name, "ir", ir, v.ir);
    chk(v.name, "ir_valid", 32'(ir_valid), 32'(v.valid));
    chk(v.name, "pc", 32'(pc), 32'(v.pc));
    chk(v.name, "busy", 32'(busy), 32'(exp_busy));
    chk(v.name, "halted", 32'(halted), 32'(v.halted));
    chk(v.name, "instr_count", 32'(instr_count), 32'(v.cnt));
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      start    = vecs[i].start;
      start_pc = vecs[i].start_pc;
      stop     = vecs[i].stop;
      ir_ready = vecs[i].ready;
      @(posedge clk);
      #1;
      check_outputs(vecs[i]);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    int seg_a;
    int seg_b;
    int seg_c;
    for (int i = 0; i < 256; i++) mem[i] = W_H;
    mem[0] = W_A; mem[1] = W_B; mem[2] = W_H;
    mem[5] = 32'h00000123; mem[6] = W_H;
    mem[8'hFF] = W_A; mem[8'h10] = 32'h00000055;

    // Basic fetch: two instructions then HALT word.
    add("b0", 1, 8'h00, 0, 1, S_FETCH, 0,     0, 8'h00, 0, 0);
    add("b1", 0, 8'h00, 0, 1, S_WAIT,  0,     0, 8'h00, 0, 0);
    add("b2", 0, 8'h00, 0, 1, S_ISSUE, W_A,   1, 8'h00, 0, 0);
    add("b3", 0, 8'h00, 0, 1, S_FETCH, W_A,   0, 8'h01, 0, 1);
    add("b4", 0, 8'h00, 0, 1, S_WAIT,  W_A,   0, 8'h01, 0, 1);
    add("b5", 0, 8'h00, 0, 1, S_ISSUE, W_B,   1, 8'h01, 0, 1);
    add("b6", 0, 8'h00, 0, 1, S_FETCH, W_B,   0, 8'h02, 0, 2);
    add("b7", 0, 8'h00, 0, 1, S_WAIT,  W_B,   0, 8'h02, 0, 2);
    add("b8", 0, 8'h00, 0, 1, S_HALT,  W_H,   0, 8'h02, 1, 2);
    add("b9", 0, 8'h00, 0, 1, S_HALT,  W_H,   0, 8'h02, 1, 2);
    // Backpressure: five stalled cycles in ISSUE.
    add("p0", 1, 8'h05, 0, 0, S_FETCH, W_H,   0, 8'h05, 0, 0);
    add("p1", 0, 8'h00, 0, 0, S_WAIT,  W_H,   0, 8'h05, 0, 0);
    add("p2", 0, 8'h00, 0, 0, S_ISSUE, 32'h123, 1, 8'h05, 0, 0);
    for (int k = 0; k < 5; k++)
      add($sformatf("p_stall%0d", k), 0, 8'h00, 0, 0, S_ISSUE, 32'h123, 1, 8'h05, 0, 0);
    add("p8", 0, 8'h00, 0, 1, S_FETCH, 32'h123, 0, 8'h06, 0, 1);
    add("p9", 0, 8'h00, 0, 1, S_WAIT,  32'h123, 0, 8'h06, 0, 1);
    add("p10", 0, 8'h00, 0, 1, S_HALT, W_H,   0, 8'h06, 1, 1);
    seg_a = vecs.size();
    // Wrap-around from 0xFF to 0x00.
    add("w0", 1, 8'hFF, 0, 1, S_FETCH, W_H,   0, 8'hFF, 0, 0);
    add("w1", 0, 8'h00, 0, 1, S_WAIT,  W_H,   0, 8'hFF, 0, 0);
    add("w2", 0, 8'h00, 0, 1, S_ISSUE, W_A,   1, 8'hFF, 0, 0);
    add("w3", 0, 8'h00, 0, 1, S_FETCH, W_A,   0, 8'h00, 0, 1);
    add("w4", 0, 8'h00, 0, 1, S_WAIT,  W_A,   0, 8'h00, 0, 1);
    add("w5", 0, 8'h00, 0, 1, S_HALT,  W_H,   0, 8'h00, 1, 1);
    // Restart after HALT at start_pc=1.
    add("r0", 1, 8'h01, 0, 1, S_FETCH, W_H,   0, 8'h01, 0, 0);
    add("r1", 0, 8'h00, 0, 1, S_WAIT,  W_H,   0, 8'h01, 0, 0);
    add("r2", 0, 8'h00, 0, 1, S_ISSUE, W_B,   1, 8'h01, 0, 0);
    add("r3", 0, 8'h00, 0, 1, S_FETCH, W_B,   0, 8'h02, 0, 1);
    add("r4", 0, 8'h00, 0, 1, S_WAIT,  W_B,   0, 8'h02, 0, 1);
    add("r5", 0, 8'h00, 0, 1, S_HALT,  W_H,   0, 8'h02, 1, 1);
    // Abort in WAIT, start+stop in IDLE, stop during a handshake.
    add("a0", 1, 8'h10, 0, 1, S_FETCH, W_H,   0, 8'h10, 0, 0);
    add("a1", 0, 8'h00, 0, 1, S_WAIT,  W_H,   0, 8'h10, 0, 0);
    add("a2", 0, 8'h00, 1, 1, S_IDLE,  W_H,   0, 8'h10, 0, 0);
    add("a3", 0, 8'h00, 0, 1, S_IDLE,  W_H,   0, 8'h10, 0, 0);
    add("a4", 1, 8'h20, 1, 1, S_IDLE,  W_H,   0, 8'h10, 0, 0);
    add("a5", 0, 8'h00, 0, 1, S_IDLE,  W_H,   0, 8'h10, 0, 0);
    add("a6", 1, 8'h10, 0, 1, S_FETCH, W_H,   0, 8'h10, 0, 0);
    add("a7", 0, 8'h00, 0, 1, S_WAIT,  W_H,   0, 8'h10, 0, 0);
    add("a8", 0, 8'h00, 0, 1, S_ISSUE, 32'h55, 1, 8'h10, 0, 0);
    add("a9", 0, 8'h00, 1, 1, S_IDLE,  32'h55, 0, 8'h10, 0, 0);
    // Reach ISSUE with a nonzero count before the async reset.
    add("q0", 1, 8'h05, 0, 1, S_FETCH, 32'h55, 0, 8'h05, 0, 0);
    add("q1", 0, 8'h00, 0, 1, S_WAIT,  32'h55, 0, 8'h05, 0, 0);
    add("q2", 0, 8'h00, 0, 1, S_ISSUE, 32'h123, 1, 8'h05, 0, 0);
    add("q3", 0, 8'h00, 0, 1, S_FETCH, 32'h123, 0, 8'h06, 0, 1);
    add("q4", 0, 8'h00, 0, 0, S_WAIT,  32'h123, 0, 8'h06, 0, 1);
    add("q5", 0, 8'h00, 0, 0, S_ISSUE, 32'h124, 1, 8'h06, 0, 1);
    seg_b = vecs.size();
    // Normal fetch after the async reset.
    add("c0", 1, 8'h05, 0, 1, S_FETCH, 0,     0, 8'h05, 0, 0);
    add("c1", 0, 8'h00, 0, 1, S_WAIT,  0,     0, 8'h05, 0, 0);
    add("c2", 0, 8'h00, 0, 1, S_ISSUE, 32'h123, 1, 8'h05, 0, 0);
    add("c3", 0, 8'h00, 0, 1, S_FETCH, 32'h123, 0, 8'h06, 0, 1);
    seg_c = vecs.size();

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check_outputs('{"reset", 0, 0, 0, 0, S_IDLE, 0, 0, 8'h00, 0, 0});
    chk("reset", "imem_addr", 32'(imem_addr), 32'h0);
    reset = 1'b1;

    run(0, seg_a);
    mem[0] = W_H;
    mem[6] = 32'h00000124;
    run(seg_a, seg_b);

    // Async reset between edges while in ISSUE.
    #2 reset = 1'b0;
    #1;
    check_outputs('{"async_rst", 0, 0, 0, 0, S_IDLE, 0, 0, 8'h00, 0, 0});
    chk("async_rst", "imem_addr", 32'(imem_addr), 32'h0);
    reset = 1'b1;

    run(seg_b, seg_c);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
